mesi_broad_dispatch: RTL and testbench

//  Drains the broadcast FIFO filled by the request-queue controller: pops the head entry, issues a snoop to

---
 rtl/mesi_isc_pkg.sv | 42 ++++
 rtl/mesi_ack_watchdog.sv | 31 +++
 rtl/mesi_broad_dispatch.sv | 138 +++++++++++++
 tb/tb_mesi_broad_dispatch.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesi_isc_pkg.sv
// Shared encodings for the MESI broadcast dispatch path: command bus values,
// broadcast FIFO entry types and the dispatcher FSM states.
package mesi_isc_pkg;

  localparam int unsigned CmdW = 3;

  // One per-CPU command slot on the command bus.
  typedef logic [CmdW-1:0] cmd_t;

  localparam cmd_t CmdNop     = 3'd0;
  localparam cmd_t CmdWrSnoop = 3'd1;
  localparam cmd_t CmdRdSnoop = 3'd2;
  localparam cmd_t CmdEnWr    = 3'd3;
  localparam cmd_t CmdEnRd    = 3'd4;

  typedef enum logic [1:0] {
    BroadBad0 = 2'd0,
    BroadWr   = 2'd1,
    BroadRd   = 2'd2,
    BroadBad3 = 2'd3
  } broad_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StSnoop,
    StEnable,
    StPop
  } state_e;

  function automatic logic broad_type_legal(logic [1:0] t);
    return (t == BroadWr) || (t == BroadRd);
  endfunction

  function automatic cmd_t snoop_cmd(logic is_wr);
    return is_wr ? CmdWrSnoop : CmdRdSnoop;
  endfunction

  function automatic cmd_t enable_cmd(logic is_wr);
    return is_wr ? CmdEnWr : CmdEnRd;
  endfunction

endpackage

// File: rtl/mesi_ack_watchdog.sv
// Ack-phase watchdog: counts cycles spent waiting in a phase and flags expiry
// on the TIMEOUT-th cycle. TIMEOUT of 0 disables it.
module mesi_ack_watchdog
  import mesi_isc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CntW    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CntW-1:0] Last = CntW'((TIMEOUT == 0) ? 32'd0 : TIMEOUT - 32'd1);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable && (count_q != Last)) begin
      count_q <= count_q + CntW'(1);
    end
  end

  // A clear in the same cycle means the phase just completed, so it wins.
  assign expire = (TIMEOUT != 0) && enable && !clear && (count_q == Last);

endmodule

// File: rtl/mesi_broad_dispatch.sv
// Broadcast dispatcher: pops the broadcast FIFO head, snoops every CPU except
// the originator, then grants the originator; one transaction in flight.
module mesi_broad_dispatch
  import mesi_isc_pkg::*;
#(
  parameter int unsigned CPUS    = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ID_W    = 7,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     broad_fifo_empty,
  input  logic [ADDR_W-1:0]        broad_addr,
  input  logic [1:0]               broad_type,
  input  logic [$clog2(CPUS)-1:0]  broad_cpu_id,
  input  logic [ID_W-1:0]          broad_id,
  output logic                     broad_fifo_rd,
  output logic [3*CPUS-1:0]        cbus_cmd_array,
  output logic [ADDR_W-1:0]        cbus_addr,
  input  logic [CPUS-1:0]          cbus_ack_array,
  output logic [ID_W-1:0]          cur_id,
  output logic                     busy,
  output logic                     err_timeout,
  output logic                     err_illegal
);

  localparam int unsigned CpuW = $clog2(CPUS);

  state_e          state_q;
  cmd_t [CPUS-1:0] cmd_q;
  logic [CPUS-1:0] pending_q;
  logic [CPUS-1:0] acked;
  logic [CPUS-1:0] pending_left;
  logic [CpuW-1:0] cpu_q;
  logic            is_wr_q;
  logic            wd_clear;
  logic            wd_enable;
  logic            wd_expire;

  // An ack only counts while that CPU is actually being commanded.
  always_comb begin
    acked = '0;
    for (int i = 0; i < CPUS; i++) begin
      acked[i] = cbus_ack_array[i] && (cmd_q[i] != CmdNop);
    end
  end

  assign pending_left = pending_q & ~acked;
  assign wd_enable    = (state_q == StSnoop) || (state_q == StEnable);
  assign wd_clear     = (state_q == StIdle) || ((state_q == StSnoop) && (pending_left == '0));

  mesi_ack_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clear (wd_clear),
    .enable(wd_enable),
    .expire(wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cmd_q         <= '0;
      pending_q     <= '0;
      cpu_q         <= '0;
      is_wr_q       <= 1'b0;
      cbus_addr     <= '0;
      cur_id        <= '0;
      broad_fifo_rd <= 1'b0;
      err_timeout   <= 1'b0;
      err_illegal   <= 1'b0;
    end else begin
      broad_fifo_rd <= 1'b0;
      err_illegal   <= 1'b0;
      if (wd_expire) begin
        // Give up on the entry: silence the bus and discard it.
        cmd_q         <= '0;
        pending_q     <= '0;
        err_timeout   <= 1'b1;
        broad_fifo_rd <= 1'b1;
        state_q       <= StPop;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (!broad_fifo_empty) begin
              cbus_addr <= broad_addr;
              cur_id    <= broad_id;
              cpu_q     <= broad_cpu_id;
              is_wr_q   <= (broad_type == BroadWr);
              if (broad_type_legal(broad_type)) begin
                for (int i = 0; i < CPUS; i++) begin
                  pending_q[i] <= (CpuW'(i) != broad_cpu_id);
                  cmd_q[i]     <= (CpuW'(i) != broad_cpu_id) ?
                                  snoop_cmd(broad_type == BroadWr) : CmdNop;
                end
                state_q <= StSnoop;
              end else begin
                err_illegal   <= 1'b1;
                broad_fifo_rd <= 1'b1;
                state_q       <= StPop;
              end
            end
          end
          StSnoop: begin
            pending_q <= pending_left;
            for (int i = 0; i < CPUS; i++) begin
              if (acked[i]) cmd_q[i] <= CmdNop;
            end
            if (pending_left == '0) begin
              cmd_q[cpu_q] <= enable_cmd(is_wr_q);
              state_q      <= StEnable;
            end
          end
          StEnable: begin
            if (acked[cpu_q]) begin
              cmd_q         <= '0;
              broad_fifo_rd <= 1'b1;
              state_q       <= StPop;
            end
          end
          StPop: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign cbus_cmd_array = cmd_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_mesi_broad_dispatch.sv
// Scoreboard bench for mesi_broad_dispatch: a FIFO/CPU-agent model drives the
// DUT, expected per-transaction outcomes are queued and checked at each pop.
module tb_mesi_broad_dispatch;

  localparam int TO = 8;

  typedef struct packed {
    logic [31:0]     addr;
    logic [1:0]      typ;
    logic [1:0]      cpu;
    logic [6:0]      id;
    logic [3:0][7:0] sd;   // snoop ack delay per CPU, 8'hFF = never
    logic [7:0]      ed;   // enable ack delay, 8'hFF = never
  } ent_t;

  typedef struct packed {
    logic [31:0]     addr;
    logic [6:0]      id;
    logic [1:0]      cpu;
    logic [1:0]      kind; // 0 normal, 1 illegal, 2 timeout
    logic [2:0]      scmd;
    logic [2:0]      ecmd;
    logic [3:0][7:0] svis; // cycles each CPU should see its snoop
    logic [7:0]      evis;
    logic [15:0]     popc; // pop cycle, counted from capture cycle = 0
  } exp_t;

  logic        clk;
  logic        rst;
  logic        rst_d;
  logic        broad_fifo_empty;
  logic [31:0] broad_addr;
  logic [1:0]  broad_type;
  logic [1:0]  broad_cpu_id;
  logic [6:0]  broad_id;
  logic        broad_fifo_rd;
  logic [11:0] cbus_cmd_array;
  logic [31:0] cbus_addr;
  logic [3:0]  cbus_ack_array;
  logic [6:0]  cur_id;
  logic        busy;
  logic        err_timeout;
  logic        err_illegal;

  mesi_broad_dispatch #(
    .CPUS   (4),
    .ADDR_W (32),
    .ID_W   (7),
    .TIMEOUT(TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .broad_fifo_empty(broad_fifo_empty),
    .broad_addr      (broad_addr),
    .broad_type      (broad_type),
    .broad_cpu_id    (broad_cpu_id),
    .broad_id        (broad_id),
    .broad_fifo_rd   (broad_fifo_rd),
    .cbus_cmd_array  (cbus_cmd_array),
    .cbus_addr       (cbus_addr),
    .cbus_ack_array  (cbus_ack_array),
    .cur_id          (cur_id),
    .busy            (busy),
    .err_timeout     (err_timeout),
    .err_illegal     (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) rst_d <= rst;

  ent_t fifo_q[$];
  exp_t exp_q[$];
  int   age[4];
  int   stall_cnt = 0;
  bit   done = 0;

  function automatic exp_t model(ent_t e);
    exp_t x;
    int   worst;
    bit   never;
    x      = '0;
    x.addr = e.addr;
    x.id   = e.id;
    x.cpu  = e.cpu;
    if (e.typ == 2'd0 || e.typ == 2'd3) begin
      x.kind = 2'd1;
      x.popc = 16'd1;
      return x;
    end
    x.scmd = (e.typ == 2'd1) ? 3'd1 : 3'd2;
    x.ecmd = (e.typ == 2'd1) ? 3'd3 : 3'd4;
    worst  = 0;
    never  = 0;
    for (int i = 0; i < 4; i++) begin
      if (i != int'(e.cpu)) begin
        if (e.sd[i] == 8'hFF) begin
          never     = 1;
          x.svis[i] = 8'(TO);
        end else begin
          x.svis[i] = 8'(int'(e.sd[i]) + 1);
          if (int'(e.sd[i]) > worst) worst = int'(e.sd[i]);
        end
      end
    end
    if (never) begin
      x.kind = 2'd2;
      x.popc = 16'(TO + 1);
    end else if (e.ed == 8'hFF) begin
      x.kind = 2'd2;
      x.evis = 8'(TO);
      x.popc = 16'(2 + worst + TO);
    end else begin
      x.evis = 8'(int'(e.ed) + 1);
      x.popc = 16'(3 + worst + int'(e.ed));
    end
    return x;
  endfunction

  task automatic push_entry(input ent_t e);
    fifo_q.push_back(e);
    exp_q.push_back(model(e));
  endtask

  // One cycle of the FIFO and CPU agents, acting on the falling edge.
  task automatic tick();
    ent_t       h;
    logic [2:0] c;
    logic [3:0] a;
    int         lim;
    @(negedge clk);
    if (broad_fifo_rd === 1'b1 && fifo_q.size() > 0) fifo_q.delete(0);
    h = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    a = '0;
    for (int i = 0; i < 4; i++) begin
      c = cbus_cmd_array[3*i +: 3];
      if (c != 3'd0) begin
        lim  = (c == 3'd3 || c == 3'd4) ? int'(h.ed) : int'(h.sd[i]);
        a[i] = (lim != 255) && (age[i] == lim);
        age[i]++;
      end else begin
        age[i] = 0;
        a[i]   = !rst && ($urandom_range(0, 3) == 0);
      end
    end
    cbus_ack_array   = a;
    broad_fifo_empty = (fifo_q.size() == 0);
    broad_addr       = h.addr;
    broad_type       = h.typ;
    broad_cpu_id     = h.cpu;
    broad_id         = h.id;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((fifo_q.size() != 0 || busy !== 1'b0) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) stall_cnt++;
  endtask

  function automatic ent_t mk(input logic [31:0] addr, input logic [1:0] typ,
                              input logic [1:0] cpu, input logic [6:0] id,
                              input logic [31:0] sd, input logic [7:0] ed);
    ent_t e;
    e.addr = addr; e.typ = typ; e.cpu = cpu; e.id = id; e.sd = sd; e.ed = ed;
    return e;
  endfunction

  function automatic ent_t rand_entry();
    ent_t e;
    int   r;
    e.addr = $urandom;
    e.id   = 7'($urandom_range(0, 127));
    e.cpu  = 2'($urandom_range(0, 3));
    r      = $urandom_range(0, 9);
    e.typ  = (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : 2'($urandom_range(1, 2));
    for (int i = 0; i < 4; i++) e.sd[i] = 8'($urandom_range(0, 4));
    e.ed = 8'($urandom_range(0, 4));
    r    = $urandom_range(0, 19);
    if (r == 0) e.sd[(int'(e.cpu) + 1) % 4] = 8'hFF;
    else if (r == 1) e.ed = 8'hFF;
    return e;
  endfunction

  initial begin
    rst = 1'b1;
    broad_fifo_empty = 1'b1;
    broad_addr = '0; broad_type = '0; broad_cpu_id = '0; broad_id = '0;
    cbus_ack_array = '0;
    for (int i = 0; i < 4; i++) age[i] = 0;
    // Entry sits at the head through reset and must not be popped by it.
    push_entry(mk(32'h1000_0040, 2'd1, 2'd0, 7'd5, 32'h0000_0000, 8'd0));
    repeat (3) tick();
    rst = 1'b0;
    wait_idle();
    // RD from CPU2 with acks staggered CPU3, CPU0, CPU1.
    push_entry(mk(32'h2000_0080, 2'd2, 2'd2, 7'd9, {8'd0, 8'd0, 8'd2, 8'd1}, 8'd0));
    wait_idle();
    push_entry(mk(32'h3000_0000, 2'd0, 2'd1, 7'd11, 32'h0, 8'd0));
    push_entry(mk(32'h3000_0100, 2'd3, 2'd3, 7'd12, 32'h0, 8'd0));
    wait_idle();
    // CPU3 never acks, next entry must still be serviced.
    push_entry(mk(32'h4000_0000, 2'd1, 2'd0, 7'd20, {8'hFF, 8'd1, 8'd0, 8'd0}, 8'd0));
    push_entry(mk(32'h4000_0040, 2'd2, 2'd1, 7'd21, {8'd1, 8'd2, 8'd0, 8'd0}, 8'd1));
    wait_idle();
    // Reset during ENABLE: entry must be replayed in full afterwards.
    push_entry(mk(32'h5000_0000, 2'd1, 2'd1, 7'd30, {8'd1, 8'd0, 8'd0, 8'd2}, 8'd3));
    for (int n = 0; n < 100; n++) begin
      tick();
      if (cbus_cmd_array[5:3] == 3'd3) break;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_idle();
    for (int n = 0; n < 40; n++) begin
      push_entry(rand_entry());
      repeat ($urandom_range(0, 6)) tick();
    end
    wait_idle();
    repeat (2) tick();
    done = 1;
    repeat (10) @(negedge clk);
    $display("FAIL summary_not_reached");
    $fatal(1);
  end

  // Monitor and scoreboard.
  int   errors = 0;
  int   checks = 0;
  int   ncyc = 0;
  bit   armed = 0;
  bit   in_txn = 0;
  bit   exp_sticky = 0;
  int   exp_rd = 0;
  int   cyc, ecnt, bad, addr_bad, ill_cnt, idle_bad;
  int   scnt[4];
  logic [31:0] last_addr;
  logic [6:0]  last_id;
  exp_t cur;
  logic [2:0]  c;
  bit   have;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic clear_txn();
    cyc = 0; ecnt = 0; bad = 0; addr_bad = 0; ill_cnt = 0;
    for (int i = 0; i < 4; i++) scnt[i] = 0;
  endtask

  initial begin
    idle_bad = 0;
    last_addr = '0;
    last_id = '0;
    clear_txn();
  end

  always @(negedge clk) begin
    ncyc++;
    if (rst_d === 1'b1) begin
      armed = 1;
      check("reset_cmds", {20'd0, cbus_cmd_array}, 32'h0);
      check("reset_pop", {31'd0, broad_fifo_rd}, 32'h0);
      check("reset_busy", {31'd0, busy}, 32'h0);
      check("reset_errs", {30'd0, err_timeout, err_illegal}, 32'h0);
      check("reset_addr_id", cbus_addr | {25'd0, cur_id}, 32'h0);
      in_txn = 0; exp_sticky = 0; last_addr = '0; last_id = '0;
      clear_txn();
    end else if (armed) begin
      if (busy === 1'b1) begin
        if (!in_txn) begin
          in_txn = 1;
          clear_txn();
        end
        cyc++;
        have = (exp_rd < exp_q.size());
        cur  = have ? exp_q[exp_rd] : '0;
        for (int i = 0; i < 4; i++) begin
          c = cbus_cmd_array[3*i +: 3];
          if (c != 3'd0) begin
            if (cbus_addr !== cur.addr || cur_id !== cur.id) addr_bad++;
            if (cur.kind != 2'd1 && i != int'(cur.cpu) && c == cur.scmd) scnt[i]++;
            else if (cur.kind != 2'd1 && i == int'(cur.cpu) && c == cur.ecmd) ecnt++;
            else bad++;
          end
        end
        if (err_illegal === 1'b1) ill_cnt++;
        if (broad_fifo_rd === 1'b1) begin
          check("txn_expected", {31'd0, have}, 32'h1);
          check("pop_cycle", cyc, {16'd0, cur.popc});
          for (int i = 0; i < 4; i++)
            check($sformatf("snoop_cycles_cpu%0d", i), scnt[i], {24'd0, cur.svis[i]});
          check("enable_cycles", ecnt, {24'd0, cur.evis});
          check("wrong_cmd_cycles", bad, 32'h0);
          check("addr_id_mismatch", addr_bad, 32'h0);
          check("err_illegal_cycles", ill_cnt, (cur.kind == 2'd1) ? 32'h1 : 32'h0);
          if (cur.kind == 2'd2) exp_sticky = 1;
          check("err_timeout", {31'd0, err_timeout}, {31'd0, exp_sticky});
          last_addr = cur.addr;
          last_id   = cur.id;
          exp_rd++;
          in_txn = 0;
        end
      end else begin
        in_txn = 0;
        if (cbus_cmd_array != 12'h0 || broad_fifo_rd !== 1'b0 || err_illegal !== 1'b0 ||
            cbus_addr !== last_addr || cur_id !== last_id || err_timeout !== exp_sticky)
          idle_bad++;
      end
    end
    if (done || ncyc > 60000) begin
      check("bench_cycle_budget", (ncyc > 60000) ? 32'h1 : 32'h0, 32'h0);
      check("all_txns_seen", exp_rd, exp_q.size());
      check("bounded_waits", stall_cnt, 32'h0);
      check("idle_cycle_violations", idle_bad, 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

endmodule
